// File: rtl/c_result_reader_pkg.sv
// c_result_reader_pkg: shared sizes, FSM states and width helper for the C result reader.
package c_result_reader_pkg;
   localparam int MAT_SIZE   = 6;
   localparam int DATA_WIDTH = 16;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   // Never returns 0 so a 1-row matrix still gets a legal address port.
   function automatic int clog2(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/c_result_reader_row_fifo.sv
// row_fifo: 3-entry FIFO holding returned rows with their indices; sync reset clears contents.
module row_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [3];
   logic [1:0]   wr_q, rd_q, count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < 3; i++) mem_q[i] <= '0;
      end else begin
         if (push) mem_q[wr_q] <= din;
         if (push) wr_q <= (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
         if (pop) rd_q <= (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // The issue rule upstream must make this unreachable.
   always_ff @(posedge clk) if (!rst) assert (!(push && !pop && count_q == 2'd3));

   assign dout  = mem_q[rd_q];
   assign count = count_q;
endmodule

// File: rtl/c_result_reader.sv
// c_result_reader: drains matrix C row by row from the BRAM user port onto a valid/ready stream.
// Optional C_READER_CHECKSUM_EN adds a running XOR of accepted rows on `checksum`.
module c_result_reader
   import c_result_reader_pkg::*;
#(
   parameter int N     = MAT_SIZE,
   parameter int WIDTH = DATA_WIDTH,
   parameter int ADDR  = clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 C_USR_rd,
   output logic [ADDR-1:0]      C_USR_addr,
   input  logic [N*WIDTH-1:0]   C_USR_dout,
   output logic                 row_valid,
   input  logic                 row_ready,
   output logic [N*WIDTH-1:0]   row_data,
   output logic [ADDR-1:0]      row_idx,
   output logic                 row_last,
`ifdef C_READER_CHECKSUM_EN
   output logic                 frame_done,
   output logic [N*WIDTH-1:0]   checksum
`else
   output logic                 frame_done
`endif
);
   localparam int DW = N * WIDTH;

   state_t             state_q;
   logic               busy_q, rd_q, rd_dly_q, done_q;
   logic [ADDR-1:0]    addr_q, idx_q;
   logic [1:0]         count;
   logic [2:0]         count_d;
   logic               pop, can_issue;
   logic [DW+ADDR-1:0] head;

   // Occupancy after this edge plus the read still in the BRAM pipe must leave room for one more.
   assign pop       = row_valid && row_ready;
   assign count_d   = {1'b0, count} + {2'b0, rd_dly_q} - {2'b0, pop};
   assign can_issue = (count_d + {2'b0, rd_q}) < 3'd3;

   row_fifo #(.W(DW + ADDR)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_dly_q),
      .din   ({idx_q, C_USR_dout}),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   assign row_valid        = count != 2'd0;
   assign {row_idx, row_data} = head;
   assign row_last         = row_valid && row_idx == ADDR'(N - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         rd_q     <= 1'b0;
         rd_dly_q <= 1'b0;
         addr_q   <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         rd_dly_q <= rd_q;
         idx_q    <= addr_q;
         done_q   <= 1'b0;
         rd_q     <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q <= (N == 1) ? DRAIN : READ;
               busy_q  <= 1'b1;
               rd_q    <= 1'b1;
               addr_q  <= '0;
            end
            READ: if (can_issue) begin
               rd_q   <= 1'b1;
               addr_q <= addr_q + ADDR'(1);
               if (addr_q == ADDR'(N - 2)) state_q <= DRAIN;
            end
            DRAIN: if (pop && row_last) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign C_USR_rd   = rd_q;
   assign C_USR_addr = addr_q;
   assign frame_done = done_q;

`ifdef C_READER_CHECKSUM_EN
   logic [DW-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst || (state_q == IDLE && start)) sum_q <= '0;
      else if (pop) sum_q <= sum_q ^ row_data;
   end

   assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_c_result_reader.sv
// tb_c_result_reader: scoreboard bench with a BRAM model and random/backpressured row_ready.
module tb_c_result_reader;
   import c_result_reader_pkg::*;
   localparam int N = MAT_SIZE, WIDTH = DATA_WIDTH, ADDR = clog2(N), DW = N * WIDTH;

   typedef struct { logic [DW-1:0] data; logic [ADDR-1:0] idx; } row_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, row_ready = 1'b1;
   logic busy, C_USR_rd, row_valid, row_last, frame_done;
   logic [ADDR-1:0] C_USR_addr, row_idx;
   logic [DW-1:0] C_USR_dout = '0, row_data;
`ifdef C_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   logic [DW-1:0] mem [N];
   row_t exp_q[$];
   logic [DW-1:0] exp_sum = '0;
   int checks = 0, errors = 0, cyc = 0, t0 = 0, mode = 0;
   int done_cnt = 0, done_cyc = -1, first_valid = -1, rd_cnt = 0;
   logic hold = 1'b0;
   logic [DW+ADDR-1:0] prev = '0;

   c_result_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .C_USR_rd   (C_USR_rd),
      .C_USR_addr (C_USR_addr),
      .C_USR_dout (C_USR_dout),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .row_data   (row_data),
      .row_idx    (row_idx),
      .row_last   (row_last),
`ifdef C_READER_CHECKSUM_EN
      .frame_done (frame_done),
      .checksum   (checksum)
`else
      .frame_done (frame_done)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) if (C_USR_rd) C_USR_dout <= mem[C_USR_addr];

   always @(posedge clk) begin
      #1;
      row_ready = (mode == 2) ? 1'($urandom_range(0, 1)) :
                  (mode == 1) ? !(cyc >= t0 + 3 && cyc <= t0 + 10) : 1'b1;
   end

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rd"}, C_USR_rd, 0);
      chk({tag, "_addr"}, C_USR_addr, 0);
      chk({tag, "_row_valid"}, row_valid, 0);
      chk({tag, "_row_data"}, row_data, 0);
      chk({tag, "_row_idx"}, row_idx, 0);
      chk({tag, "_row_last"}, row_last, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
`ifdef C_READER_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   // The expected frame is simply every memory row in address order.
   task automatic issue_start();
      exp_sum = '0;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back('{mem[i], ADDR'(i)});
         exp_sum ^= mem[i];
      end
      first_valid = -1;
      rd_cnt = 0;
      t0 = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_t1", busy, 1);
      chk("rd_t1", C_USR_rd, 1);
      chk("addr_t1", C_USR_addr, 0);
   endtask

   task automatic wait_frame(input int exp_done);
      int n = 0;
      while (done_cnt < exp_done && n < 200) begin
         tick();
         n++;
      end
      chk("frame_done_count", done_cnt, exp_done);
   endtask

   always @(negedge clk) begin : monitor
      row_t e;
      if (rst) hold = 1'b0;
      else begin
         if (hold) chk("row_stable", {row_idx, row_data}, prev);
         if (row_valid && row_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL row_extra: got idx %0d expected no row (cycle %0d)", row_idx, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("row_data", row_data, e.data);
               chk("row_idx", row_idx, e.idx);
               chk("row_last", row_last, e.idx == ADDR'(N - 1));
            end
         end
         hold = row_valid && !row_ready;
         prev = {row_idx, row_data};
         if (C_USR_rd) rd_cnt++;
         if (row_valid && first_valid < 0) first_valid = cyc;
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
            chk("rows_left_at_done", exp_q.size(), 0);
`ifdef C_READER_CHECKSUM_EN
            chk("checksum", checksum, exp_sum);
`endif
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 96'h000600050004000300020001;
      repeat (3) tick();
      @(negedge clk);
      chk_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      issue_start();
      wait_frame(1);
      chk("first_row_cycle", first_valid, t0 + 3);
      chk("frame_done_cycle", done_cyc, t0 + 9);

      mode = 1;
      issue_start();
      while (cyc < t0 + 10) tick();
      @(negedge clk);
      chk("reads_under_bp_le3", rd_cnt <= 3, 1);
      chk("row_valid_under_bp", row_valid, 1);
      wait_frame(2);

      mode = 2;
      for (int i = 0; i < N; i++) mem[i] = {N{WIDTH'(i + 1)}};
      issue_start();
      wait_frame(3);
`ifdef C_READER_CHECKSUM_EN
      chk("checksum_const", checksum, 96'h000700070007000700070007);
      repeat (3) tick();
      chk("checksum_held", checksum, exp_sum);
`endif
      for (int i = 0; i < N; i++) mem[i] = {$urandom(), $urandom(), $urandom()};
      issue_start();
      wait_frame(4);

      mode = 0;
      issue_start();
      while (cyc < t0 + 4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_frame(5);
      repeat (12) tick();
      chk("no_extra_frame", done_cnt, 5);
      chk("queue_empty", exp_q.size(), 0);
      issue_start();
      wait_frame(6);

      issue_start();
      while (cyc < t0 + 5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk_zero("midreset");
      repeat (15) tick();
      chk("no_done_after_reset", done_cnt, 6);
      issue_start();
      wait_frame(7);
      chk("frame_done_cycle_after_reset", done_cyc, t0 + 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
